// File: rtl/pim_arb_pkg.sv
// Shared types and default constants for the PIM bus arbiter family.
package pim_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_TURN
    } arb_state_e;

    localparam int ARB_MAX_HOLD_DEFAULT = 256;
    localparam int ARB_GAP_DEFAULT      = 1;

endpackage

// File: rtl/pim_rr_picker.sv
// Combinational round-robin picker: starting just after last_owner and
// wrapping, returns the first requesting master as one-hot and as an index.
// Also intended for the command-path arbiter.
module pim_rr_picker
    import pim_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [$clog2(NUM_MASTERS)-1:0] last_owner,
    output logic [NUM_MASTERS-1:0]         winner,
    output logic [$clog2(NUM_MASTERS)-1:0] winner_id
);

    localparam int ID_W = $clog2(NUM_MASTERS);

    logic found;
    int   idx;

    // Walk offsets 1..N from last_owner; the first requester found wins,
    // so last_owner itself gets the lowest priority.
    always_comb begin
        winner    = '0;
        winner_id = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last_owner) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pim_bus_arbiter.sv
// Round-robin, grant-locking arbiter for the shared PIM memory bus.
// An owner keeps the bus until done, abandonment, or hold timeout; every
// release is followed by GAP_CYCLES of idle turnaround.
module pim_bus_arbiter
    import pim_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_HOLD_CYCLES = ARB_MAX_HOLD_DEFAULT,
    parameter int GAP_CYCLES      = ARB_GAP_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [NUM_MASTERS-1:0]         done,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] owner_id,
    output logic                           bus_busy,
    output logic                           timeout_err,
    output logic [$clog2(NUM_MASTERS)-1:0] timeout_id
);

    localparam int ID_W   = $clog2(NUM_MASTERS);
    localparam int HOLD_W = $clog2(MAX_HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_masters
        $error("pim_bus_arbiter: NUM_MASTERS must be 2..8");
    end
    if (MAX_HOLD_CYCLES < 2) begin : g_bad_hold
        $error("pim_bus_arbiter: MAX_HOLD_CYCLES must be >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("pim_bus_arbiter: GAP_CYCLES must be >= 1");
    end

    arb_state_e              state, state_nx;
    logic [HOLD_W-1:0]       hold_cnt, hold_nx;
    logic [GAP_W-1:0]        gap_cnt, gap_nx;
    logic [ID_W-1:0]         last_owner, last_nx;
    logic [NUM_MASTERS-1:0]  gnt_nx;
    logic [ID_W-1:0]         owner_nx;
    logic                    terr_nx;
    logic [ID_W-1:0]         tid_nx;
    logic                    rel;

    logic [NUM_MASTERS-1:0]  pick_gnt;
    logic [ID_W-1:0]         pick_id;

    pim_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req        (req),
        .last_owner (last_owner),
        .winner     (pick_gnt),
        .winner_id  (pick_id)
    );

    assign bus_busy = (state == ARB_GRANT);

    // Next-state and next-output logic; done from non-owners never reaches
    // the decision since only done[owner_id] is looked at.
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        owner_nx = owner_id;
        hold_nx  = hold_cnt;
        gap_nx   = gap_cnt;
        last_nx  = last_owner;
        terr_nx  = 1'b0;
        tid_nx   = timeout_id;
        rel      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (|req) begin
                    state_nx = ARB_GRANT;
                    gnt_nx   = pick_gnt;
                    owner_nx = pick_id;
                    hold_nx  = '0;
                end
            end
            ARB_GRANT: begin
                // done wins over a coincident timeout: a finished transfer
                // is never reported as an error.
                if (done[owner_id]) begin
                    rel = 1'b1;
                end else if (!req[owner_id]) begin
                    rel = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    rel     = 1'b1;
                    terr_nx = 1'b1;
                    tid_nx  = owner_id;
                end
                if (rel) begin
                    state_nx = ARB_TURN;
                    last_nx  = owner_id;
                    gnt_nx   = '0;
                    gap_nx   = '0;
                end else begin
                    hold_nx = hold_cnt + HOLD_W'(1);
                end
            end
            ARB_TURN: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = ARB_IDLE;
                end else begin
                    gap_nx = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_nx = ARB_IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    // State and output registers; last_owner resets to the top index so
    // master 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            gnt         <= '0;
            owner_id    <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            last_owner  <= ID_W'(NUM_MASTERS - 1);
            timeout_err <= 1'b0;
            timeout_id  <= '0;
        end else begin
            state       <= state_nx;
            gnt         <= gnt_nx;
            owner_id    <= owner_nx;
            hold_cnt    <= hold_nx;
            gap_cnt     <= gap_nx;
            last_owner  <= last_nx;
            timeout_err <= terr_nx;
            timeout_id  <= tid_nx;
        end
    end

endmodule
